// File: rtl/wb_trace_pkg.sv
// Shared types and frame layout for the writeback commit-trace UART transmitter.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  localparam int FRAME_BYTES = 10;
  localparam int ENTRY_W     = 69;
  localparam int UART_BITS   = 10;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  localparam int BYTE_SYNC   = 0;
  localparam int BYTE_PC0    = 1;
  localparam int BYTE_ADDR   = 5;
  localparam int BYTE_WDATA0 = 6;
  localparam int BYTE_LAST   = FRAME_BYTES - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } entry_t;

  typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

  // Multi-byte fields go out most significant byte first.
  function automatic frame_t build_frame(input entry_t e, input logic [7:0] sync);
    frame_t f;
    f                  = '0;
    f[BYTE_SYNC]       = sync;
    f[BYTE_PC0]        = e.pc[31:24];
    f[BYTE_PC0 + 1]    = e.pc[23:16];
    f[BYTE_PC0 + 2]    = e.pc[15:8];
    f[BYTE_PC0 + 3]    = e.pc[7:0];
    f[BYTE_ADDR]       = {3'b000, e.addr};
    f[BYTE_WDATA0]     = e.wdata[31:24];
    f[BYTE_WDATA0 + 1] = e.wdata[23:16];
    f[BYTE_WDATA0 + 2] = e.wdata[15:8];
    f[BYTE_WDATA0 + 3] = e.wdata[7:0];
    return f;
  endfunction

endpackage

// File: rtl/wb_trace_tx_uart.sv
// UART 8N1 byte transmitter; a new start is accepted while idle or in the
// final stop-bit cycle so consecutive bytes leave with no gap.
module uart_tx_byte
  import wb_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       ready
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             active_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_reg;
  logic [8:0]       shift_reg;
  logic             tx_reg;
  logic             bit_end;

  assign bit_end = active_reg && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_reg == 4'(UART_BITS - 1));
  assign ready   = !active_reg;
  assign tx      = tx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '1;
      tx_reg     <= 1'b1;
    end else if (start && (ready || done)) begin
      active_reg <= 1'b1;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= {1'b1, data};
      tx_reg     <= 1'b0;
    end else if (done) begin
      active_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else if (bit_end) begin
      // The stop bit is the 1 pre-loaded above the data, shifted down last.
      cnt_reg    <= '0;
      bit_reg    <= bit_reg + 1'b1;
      tx_reg     <= shift_reg[0];
      shift_reg  <= {1'b1, shift_reg[8:1]};
    end else if (active_reg) begin
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_trace_tx.sv
// Captures non-r0 writeback commits into a FIFO and sends each as a 10-byte
// UART frame: sync, pc, addr, wdata.
module wb_trace_tx
  import wb_trace_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   debug_wb_pc,
  input  logic                          debug_wb_rf_wen,
  input  logic [4:0]                    debug_wb_rf_addr,
  input  logic [31:0]                   debug_wb_rf_wdata,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg;
  logic [15:0]       drop_reg;

  logic [ENTRY_W-1:0] push_entry;
  logic               push_req, push_ok, drop, pop;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  byte_idx_reg, byte_idx_next;
  frame_t            frame_reg;

  logic              uart_start, uart_done, uart_ready;
  logic [7:0]        uart_data;

  assign push_entry = {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
  assign push_req   = debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);
  // Fullness is judged on the occupancy before any same-cycle pop.
  assign push_ok    = push_req && (count_reg < CNT_W'(FIFO_DEPTH));
  assign drop       = push_req && !push_ok;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= entry_t'(push_entry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != 16'hFFFF) drop_reg <= drop_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    uart_start    = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        byte_idx_next = '0;
        state_next    = SEND;
      end
      SEND: begin
        // Chaining the next byte on done keeps the bytes of a frame contiguous.
        if (uart_done) begin
          if (byte_idx_reg == IDX_W'(BYTE_LAST)) begin
            state_next = IDLE;
          end else begin
            byte_idx_next = byte_idx_reg + 1'b1;
            uart_start    = 1'b1;
          end
        end else if (uart_ready) begin
          uart_start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    uart_data = frame_reg[byte_idx_next];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      frame_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      if (pop) frame_reg <= build_frame(mem[rd_ptr_reg], SYNC_BYTE);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (uart_data),
    .tx    (tx),
    .done  (uart_done),
    .ready (uart_ready)
  );

  assign busy       = (count_reg != '0) || (state_reg != IDLE);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Randomized bench for wb_trace_tx: a queue-based commit model predicts frames,
// timing and counters; a line decoder reconstructs bytes from tx.
module tb_wb_trace_tx;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int BYTE_CYC  = 10 * CPB;
  localparam int FRAME_CYC = 100 * CPB;
  localparam int POP_GAP   = FRAME_CYC + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic [4:0]  addr = '0;
  logic        tx, busy, overflow;
  logic [2:0]  fifo_count;
  logic [15:0] drop_count;

  wb_trace_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk               (clk),
    .reset             (reset),
    .debug_wb_pc       (pc),
    .debug_wb_rf_wen   (wen),
    .debug_wb_rf_addr  (addr),
    .debug_wb_rf_wdata (wdata),
    .tx                (tx),
    .busy              (busy),
    .fifo_count        (fifo_count),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    int         start_t;
  } exp_byte_t;

  logic [68:0] model_q[$];
  exp_byte_t   exp_q[$];
  logic [7:0]  rx_log[$];
  int          rx_start[$];
  int          cyc = 0;
  int          pop_ready = 0;
  int          model_drops = 0;
  bit          model_ovf = 1'b0;
  bit          chk_en = 1'b1;

  // Reference model: FIFO of commits; a frame leaves 2 edges after its pop
  // and the next pop can happen POP_GAP edges after the previous one.
  int          m_nbefore;
  logic [68:0] m_e;
  logic [79:0] m_fb;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      model_q.delete();
      exp_q.delete();
      model_drops = 0;
      model_ovf   = 1'b0;
      pop_ready   = 0;
    end else begin
      cyc++;
      m_nbefore = model_q.size();
      if (m_nbefore > 0 && cyc >= pop_ready) begin
        m_e  = model_q.pop_front();
        m_fb = {8'hA5, m_e[68:37], 3'b000, m_e[36:32], m_e[31:0]};
        for (int k = 0; k < 10; k++)
          exp_q.push_back('{m_fb[79-8*k -: 8], cyc + 2 + BYTE_CYC*k});
        pop_ready = cyc + POP_GAP;
      end
      if (wen && addr != 5'd0) begin
        if (m_nbefore < DEPTH) model_q.push_back({pc, addr, wdata});
        else begin
          model_ovf = 1'b1;
          if (model_drops < 65535) model_drops++;
        end
      end
    end
  end

  // Per-cycle status comparison against the model.
  bit c_busy;
  initial forever begin
    @(negedge clk);
    if (chk_en && !reset) begin
      c_busy = (model_q.size() != 0) || (cyc < pop_ready - 1);
      checks++;
      if (fifo_count !== 3'(model_q.size()) || overflow !== model_ovf ||
          drop_count !== 16'(model_drops) || busy !== c_busy) begin
        errors++;
        $display("FAIL status cyc=%0d: got cnt=%0d ovf=%0b drops=%0d busy=%0b, want cnt=%0d ovf=%0b drops=%0d busy=%0b",
                 cyc, fifo_count, overflow, drop_count, busy,
                 model_q.size(), model_ovf, model_drops, c_busy);
      end
    end
  end

  // UART line decoder: samples every cycle of every bit.
  logic [9:0] d_bits;
  bit         d_glitch, d_abort;
  int         d_s;
  exp_byte_t  d_e;
  initial forever begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      d_s = cyc; d_glitch = 0; d_abort = 0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset) d_abort = 1;
          if (c == 0) d_bits[b] = tx;
          else if (tx !== d_bits[b]) d_glitch = 1;
        end
      end
      if (!d_abort) begin
        rx_log.push_back(d_bits[8:1]);
        rx_start.push_back(d_s);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uart_byte: got unexpected byte %02h at cyc %0d, want no byte", d_bits[8:1], d_s);
        end else begin
          d_e = exp_q.pop_front();
          if (d_bits[0] !== 1'b0 || d_bits[9] !== 1'b1 || d_glitch ||
              d_bits[8:1] !== d_e.data || d_s !== d_e.start_t) begin
            errors++;
            $display("FAIL uart_byte: got %02h start@%0d stop=%0b glitch=%0b, want %02h start@%0d stop=1",
                     d_bits[8:1], d_s, d_bits[9], d_glitch, d_e.data, d_e.start_t);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %0b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
    reset = 1'b0;
    $display("reset released at cyc %0d", cyc);
  endtask

  task automatic test_single();
    logic [7:0] gold [10] = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h10, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int push_t, n;
    rx_log.delete(); rx_start.delete();
    @(negedge clk);
    pc = 32'h0040_0010; addr = 5'd8; wdata = 32'hDEAD_BEEF; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0; push_t = cyc;
    n = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (!busy) break;
    end
    checks++;
    if (n != FRAME_CYC + 3) begin errors++; $display("FAIL single_busy_len: got %0d cycles want %0d", n, FRAME_CYC + 3); end
    checks++;
    if (rx_log.size() != 10) begin
      errors++; $display("FAIL single_nbytes: got %0d want 10", rx_log.size());
    end else begin
      checks++;
      if (rx_start[0] - push_t != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", rx_start[0] - push_t); end
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (rx_log[k] !== gold[k]) begin errors++; $display("FAIL single_byte%0d: got %02h want %02h", k, rx_log[k], gold[k]); end
      end
    end
    $display("single commit frame done, %0d bytes seen", rx_log.size());
  endtask

  task automatic test_r0_ignore();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL r0_ignore[%0d]: got cnt=%0d tx=%0b busy=%0b want 0 1 0", i, fifo_count, tx, busy);
      end
      pc = $urandom; wdata = $urandom;
      if (i[0]) begin wen = 1'b0; addr = 5'd5; end
      else begin wen = 1'b1; addr = 5'd0; end
    end
    @(negedge clk); wen = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || tx !== 1'b1) begin
      errors++; $display("FAIL r0_final: got cnt=%0d tx=%0b want 0 1", fifo_count, tx);
    end
    $display("r0/wen=0 writes ignored check done");
  endtask

  task automatic test_burst();
    logic [31:0] pcs [6];
    bit ok;
    rx_log.delete(); rx_start.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pcs[i] = $urandom; pc = pcs[i]; wdata = $urandom;
      addr = 5'($urandom_range(31, 1)); wen = 1'b1;
    end
    @(negedge clk); wen = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL burst_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf: got %0b want 1", overflow); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL burst_drops: got %0d want 1", drop_count); end
    wait_drain(5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_drain: got timeout want drained"); end
    checks++;
    if (rx_log.size() != 50) begin
      errors++; $display("FAIL burst_nbytes: got %0d want 50", rx_log.size());
    end else begin
      for (int f = 0; f < 5; f++) begin
        checks++;
        if (rx_log[10*f + 4] !== pcs[f][7:0]) begin
          errors++; $display("FAIL burst_order%0d: got pc lsb %02h want %02h", f, rx_log[10*f + 4], pcs[f][7:0]);
        end
        if (f > 0) begin
          checks++;
          if (rx_start[10*f] - rx_start[10*f - 1] != BYTE_CYC + 3) begin
            errors++; $display("FAIL burst_gap%0d: got %0d want %0d", f, rx_start[10*f] - rx_start[10*f - 1], BYTE_CYC + 3);
          end
        end
      end
    end
    $display("burst of 6: %0d frames seen", rx_log.size() / 10);
  endtask

  task automatic test_full_pop();
    int n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc = $urandom; wdata = $urandom; addr = 5'($urandom_range(31, 1)); wen = 1'b1;
    end
    @(negedge clk); wen = 1'b0;
    n = 0;
    while (cyc != pop_ready - 1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL full_pop_wait: got timeout want pop slot"); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_pop_pre: got %0d want 4", fifo_count); end
    pc = $urandom; wdata = $urandom; addr = 5'($urandom_range(31, 1)); wen = 1'b1;
    @(negedge clk); wen = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", fifo_count); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL full_pop_drops: got %0d want 2", drop_count); end
    $display("push into full FIFO with pop at cyc %0d", cyc);
  endtask

  task automatic test_reset_midframe();
    int target, n;
    target = pop_ready - POP_GAP + 2 + 3*BYTE_CYC + 5;
    n = 0;
    while (cyc != target && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL midframe_wait: got timeout want byte 3"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: got %0b want 1", tx); end
    checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL midframe_state: got busy=%0b cnt=%0d want 0 0", busy, fifo_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx[%0d]: got %0b want 1", i, tx); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL post_reset_ovf: got %0b want 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL post_reset_drops: got %0d want 0", drop_count); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", fifo_count); end
    $display("reset during byte 3 handled");
  endtask

  task automatic test_saturation();
    bit ok;
    chk_en = 1'b0;
    for (int i = 0; i < 65800; i++) begin
      @(negedge clk);
      pc = $urandom; wdata = $urandom; addr = 5'($urandom_range(31, 1)); wen = 1'b1;
    end
    @(negedge clk); wen = 1'b0;
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_drops: got %04h want FFFF", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0b want 1", overflow); end
    checks++; if (fifo_count !== 3'(model_q.size())) begin
      errors++; $display("FAIL sat_count: got %0d want %0d", fifo_count, model_q.size());
    end
    wait_drain(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_drain: got timeout want drained"); end
    chk_en = 1'b1;
    $display("saturation run done, model drops=%0d", model_drops);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_r0_ignore();
    test_burst();
    test_full_pop();
    test_reset_midframe();
    test_saturation();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
